// File: rtl/ask_symbol_slicer_if.sv
// ask_symbol_slicer_if
// Bundles the sample-rate input stream, the slicer controls and the symbol /
// error-monitor outputs of ask_symbol_slicer.
//
// Handshake: there is no backpressure. sam_clk_en qualifies one sample of
// y_in per assertion and sym_clk_en marks the first sample of a symbol. On the
// output side sym_valid and acc_done are single-cycle strobes. sym_out and
// err_acc hold their value between strobes and must be consumed on the strobe
// cycle.
interface ask_symbol_slicer_if #(
    parameter int SPS      = 4,
    parameter int ACC_LOG2 = 6
);
    localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;

    logic                     sam_clk_en;
    logic                     sym_clk_en;
    logic signed [17:0]       y_in;
    logic        [PW-1:0]     phase_sel;
    logic signed [17:0]       ref_level;
    logic        [1:0]        sym_out;
    logic                     sym_valid;
    logic [17+ACC_LOG2:0]     err_acc;
    logic                     acc_done;

    // Upstream side: the filter chain and the control registers.
    modport master (
        output sam_clk_en, sym_clk_en, y_in, phase_sel, ref_level,
        input  sym_out, sym_valid, err_acc, acc_done
    );

    // The slicer itself.
    modport slave (
        input  sam_clk_en, sym_clk_en, y_in, phase_sel, ref_level,
        output sym_out, sym_valid, err_acc, acc_done
    );
endinterface

// File: rtl/ask_symbol_slicer.sv
// ask_symbol_slicer
// Keeps one sample per symbol at a programmable phase of the matched-filter
// output and slices it into a Gray-coded 4-ASK symbol:
//   00 = -3a, 01 = -a, 11 = +a, 10 = +3a   (ref_level = 2a)
// Pipeline: capture at E0, decision and sym_valid at E0+1, error block
// result and acc_done at E0+2.
// Optional feature macro: SLICER_ERR_ACC_EN builds the decision-error
// magnitude accumulator (err_acc / acc_done). Without it both outputs are 0.
module ask_symbol_slicer #(
    parameter int SPS      = 4,
    parameter int ACC_LOG2 = 6
) (
    input  logic               i_sys_clk,
    input  logic               i_reset_n,
    ask_symbol_slicer_if.slave io_bus
);
    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;

    // Sample position tracking and capture.
    logic        [CW-1:0] r_samp_cnt;
    logic        [CW-1:0] w_idx;
    logic                 w_hit;
    logic signed [17:0]   r_y_s;
    logic signed [17:0]   r_ref;
    logic                 r_cap;

    // Decision stage.
    logic signed [19:0]   w_y20;
    logic signed [19:0]   w_ref20;
    logic signed [19:0]   w_half20;
    logic signed [19:0]   w_three20;
    logic        [1:0]    w_sym;
    logic        [1:0]    r_sym_out;
    logic                 r_sym_valid;

    // An asserted sym_clk_en forces index 0 so an early symbol boundary
    // realigns the counter on that very sample.
    assign w_idx = io_bus.sym_clk_en ? '0 : r_samp_cnt;
    assign w_hit = io_bus.sam_clk_en && (w_idx == io_bus.phase_sel);

    // Sample counter: advances only on sample enables, wraps at SPS.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_samp_cnt <= '0;
        end else if (io_bus.sam_clk_en) begin
            r_samp_cnt <= w_idx + CW'(1);
        end
    end

    // Capture the chosen sample together with the threshold that applies to
    // it, so a threshold change mid-symbol only affects the next capture.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_y_s <= '0;
            r_ref <= '0;
            r_cap <= 1'b0;
        end else begin
            r_cap <= w_hit;
            if (w_hit) begin
                r_y_s <= io_bus.y_in;
                r_ref <= io_bus.ref_level;
            end
        end
    end

    // 20-bit working copies leave headroom for -ref and 3*ref/2.
    assign w_y20     = {{2{r_y_s[17]}}, r_y_s};
    assign w_ref20   = {{2{r_ref[17]}}, r_ref};
    assign w_half20  = w_ref20 >>> 1;
    assign w_three20 = w_ref20 + w_half20;

    // Region decision; a sample exactly on a threshold belongs to the upper region.
    always_comb begin
        w_sym = 2'b00;
        if (w_y20 >= w_ref20) begin
            w_sym = 2'b10;
        end else if (w_y20 >= 20'sd0) begin
            w_sym = 2'b11;
        end else if (w_y20 >= -w_ref20) begin
            w_sym = 2'b01;
        end
    end

    // Register the symbol and its one-cycle valid strobe.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sym_out   <= 2'b00;
            r_sym_valid <= 1'b0;
        end else begin
            r_sym_valid <= r_cap;
            if (r_cap) begin
                r_sym_out <= w_sym;
            end
        end
    end

    assign io_bus.sym_out   = r_sym_out;
    assign io_bus.sym_valid = r_sym_valid;

`ifdef SLICER_ERR_ACC_EN
    localparam int AW = 18 + ACC_LOG2;

    logic signed [19:0]     w_level;
    logic signed [19:0]     w_err;
    logic        [19:0]     w_abs;
    logic        [17:0]     w_abs_sat;
    logic        [17:0]     r_abs_err;
    logic                   r_err_vld;
    logic        [AW-1:0]   w_sum;
    logic        [AW-1:0]   r_acc;
    logic        [ACC_LOG2-1:0] r_blk_cnt;
    logic        [AW-1:0]   r_err_acc;
    logic                   r_acc_done;

    // Ideal constellation point for the decided region.
    always_comb begin
        w_level = -w_three20;
        case (w_sym)
            2'b10:   w_level = w_three20;
            2'b11:   w_level = w_half20;
            2'b01:   w_level = -w_half20;
            default: w_level = -w_three20;
        endcase
    end

    // Error magnitude, clipped to the 18-bit unsigned range.
    assign w_err     = w_y20 - w_level;
    assign w_abs     = w_err[19] ? unsigned'(-w_err) : unsigned'(w_err);
    assign w_abs_sat = (w_abs > 20'd262143) ? 18'h3FFFF : w_abs[17:0];

    // Hold the error magnitude alongside the decision strobe.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_abs_err <= '0;
            r_err_vld <= 1'b0;
        end else begin
            r_err_vld <= r_cap;
            if (r_cap) begin
                r_abs_err <= w_abs_sat;
            end
        end
    end

    // 2^ACC_LOG2 terms of at most 2^18-1 each cannot overflow AW bits.
    assign w_sum = r_acc + AW'(r_abs_err);

    // Block accumulation: on the last symbol publish the total and restart.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc      <= '0;
            r_blk_cnt  <= '0;
            r_err_acc  <= '0;
            r_acc_done <= 1'b0;
        end else begin
            r_acc_done <= 1'b0;
            if (r_err_vld) begin
                r_blk_cnt <= r_blk_cnt + ACC_LOG2'(1);
                if (r_blk_cnt == '1) begin
                    r_err_acc  <= w_sum;
                    r_acc      <= '0;
                    r_acc_done <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign io_bus.err_acc  = r_err_acc;
    assign io_bus.acc_done = r_acc_done;
`else
    assign io_bus.err_acc  = '0;
    assign io_bus.acc_done = 1'b0;
`endif

endmodule

// File: tb/tb_ask_symbol_slicer.sv
// Testbench for ask_symbol_slicer: directed cases from the block's corner
// points plus a randomized stream, all checked through an expected-symbol
// queue that a free-running monitor drains on every sym_valid / acc_done.
`timescale 1ns/1ps
module tb_ask_symbol_slicer;
    localparam int SPS      = 4;
    localparam int ACC_LOG2 = 2;
    localparam int AW       = 18 + ACC_LOG2;
    localparam int EW       = 34;   // {due cycle[31:0], symbol[1:0]}

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    ask_symbol_slicer_if #(.SPS(SPS), .ACC_LOG2(ACC_LOG2)) bus();

    ask_symbol_slicer #(.SPS(SPS), .ACC_LOG2(ACC_LOG2)) dut (
        .i_sys_clk (sys_clk),
        .i_reset_n (reset_n),
        .io_bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int m_cnt = 0;   // reference model: sample index of the next sample
`ifdef SLICER_ERR_ACC_EN
    logic [AW-1:0] exp_acc_q[$];
    longint m_blk_sum = 0;
    int m_blk_n = 0;
    int acc_done_seen = 0;
    logic [AW-1:0] last_err_acc = '0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] slice_ref(input int y, input int r);
        if (y >= r)  return 2'b10;
        if (y >= 0)  return 2'b11;
        if (y >= -r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int abs_err_ref(input int y, input int r);
        int half, lvl, e;
        half = r / 2;
        case (slice_ref(y, r))
            2'b10:   lvl = r + half;
            2'b11:   lvl = half;
            2'b01:   lvl = -half;
            default: lvl = -(r + half);
        endcase
        e = y - lvl;
        if (e < 0) e = -e;
        if (e > 262143) e = 262143;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; presents one sample for one cycle, then idles.
    task automatic drive_sample(input int y, input bit sym, input int phase, input int r, input int gap);
        int idx;
        bus.sam_clk_en = 1'b1;
        bus.sym_clk_en = sym;
        bus.y_in       = 18'(y);
        bus.phase_sel  = 2'(phase);
        bus.ref_level  = 18'(r);
        idx = sym ? 0 : m_cnt;
        if (idx == phase) begin
            exp_q.push_back({32'(cyc + 2), slice_ref(y, r)});
`ifdef SLICER_ERR_ACC_EN
            m_blk_sum += abs_err_ref(y, r);
            m_blk_n++;
            if (m_blk_n == (1 << ACC_LOG2)) begin
                exp_acc_q.push_back(AW'(m_blk_sum));
                m_blk_sum = 0;
                m_blk_n   = 0;
            end
`endif
        end
        m_cnt = (idx + 1) % SPS;
        @(negedge sys_clk);
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.y_in = 18'($urandom_range(0, 262143));
            @(negedge sys_clk);
        end
    endtask

    // One full symbol with the given four samples.
    task automatic drive_symbol(input int s0, input int s1, input int s2, input int s3,
                                input int phase, input int r);
        drive_sample(s0, 1'b1, phase, r, 0);
        drive_sample(s1, 1'b0, phase, r, 1);
        drive_sample(s2, 1'b0, phase, r, 0);
        drive_sample(s3, 1'b0, phase, r, 2);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sym_out"},   bus.sym_out,   0);
        check({tag, "_sym_valid"}, bus.sym_valid, 0);
        check({tag, "_err_acc"},   bus.err_acc,   0);
        check({tag, "_acc_done"},  bus.acc_done,  0);
    endtask

    task automatic apply_reset(input int hold);
        reset_n = 1'b0;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        exp_q.delete();
        m_cnt = 0;
`ifdef SLICER_ERR_ACC_EN
        exp_acc_q.delete();
        m_blk_sum = 0;
        m_blk_n   = 0;
`endif
        repeat (hold) @(negedge sys_clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // Bounded wait for every expected response to come out.
    task automatic wait_drain();
        int budget;
        budget = 40;
        while (budget > 0 && (exp_q.size() != 0
`ifdef SLICER_ERR_ACC_EN
               || exp_acc_q.size() != 0
`endif
               )) begin
            @(negedge sys_clk);
            budget--;
        end
        repeat (3) @(negedge sys_clk);
        check("drain_sym_queue", exp_q.size(), 0);
`ifdef SLICER_ERR_ACC_EN
        check("drain_acc_queue", exp_acc_q.size(), 0);
`endif
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        if (bus.sym_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_sym_valid: got sym_valid=1 sym_out=%0d, expected no strobe (t=%0t)",
                         bus.sym_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sym_out", bus.sym_out, mon_e[1:0]);
                check("sym_latency_cycle", cyc, mon_e[33:2]);
            end
        end
`ifdef SLICER_ERR_ACC_EN
        if (bus.acc_done) begin
            acc_done_seen++;
            last_err_acc = bus.err_acc;
            if (exp_acc_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_acc_done: got acc_done=1 err_acc=%0d, expected no strobe (t=%0t)",
                         bus.err_acc, $time);
            end else begin
                check("err_acc", bus.err_acc, exp_acc_q.pop_front());
            end
        end
`else
        if (bus.sym_valid || bus.acc_done) begin
            check("err_acc_tied_zero", bus.err_acc, 0);
            check("acc_done_tied_zero", bus.acc_done, 0);
        end
`endif
    end

    // ---------------- stimulus ----------------
    initial begin
        int phase, r, y, base;
        bit sym;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        bus.y_in       = '0;
        bus.phase_sel  = '0;
        bus.ref_level  = 18'(65536);
        @(negedge sys_clk);
        apply_reset(3);

        // Single symbol, +3a region, latency checked by the monitor.
        drive_symbol(100000, 0, 0, 0, 0, 65536);
        wait_drain();

        // Exact thresholds at phase 0 of consecutive symbols.
        drive_symbol(65536, 0, 0, 0, 0, 65536);
        drive_symbol(0, 0, 0, 0, 0, 65536);
        drive_symbol(-65536, 0, 0, 0, 0, 65536);
        drive_symbol(-65537, 0, 0, 0, 0, 65536);
        wait_drain();

        // Phase 2 only picks the third sample.
        for (int s = 0; s < 3; s++) drive_symbol(-100000, -100000, 20000, -100000, 2, 65536);
        wait_drain();

        // Impulse train, phase swept across the symbol.
        for (int p = 0; p < SPS; p++)
            for (int s = 0; s < 2; s++) drive_symbol(131071, 0, 0, 0, p, 65536);
        wait_drain();

        // Error block of four identical +a decisions, aligned by a reset.
        apply_reset(2);
`ifdef SLICER_ERR_ACC_EN
        base = acc_done_seen;
`else
        base = 0;
`endif
        for (int s = 0; s < 4; s++) drive_symbol(40000, 40000, 40000, 40000, 0, 65536);
        wait_drain();
`ifdef SLICER_ERR_ACC_EN
        check("err_acc_block_value", last_err_acc, 28928);
        check("acc_done_count", acc_done_seen - base, 1);
`else
        check("err_acc_block_value", bus.err_acc, base);
`endif

        // Reset between capture and decision: no strobe, state cleared.
        drive_sample(100000, 1'b1, 0, 65536, 0);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge sys_clk);
        check("reset_mid_sym_valid", bus.sym_valid, 0);
        apply_reset(2);
        // No sym_clk_en after release: index counts 0,1,... so phase 1 hits the second sample.
        drive_sample(-100000, 1'b0, 1, 65536, 0);
        drive_sample(-20000,  1'b0, 1, 65536, 0);
        drive_sample(90000,   1'b0, 1, 65536, 0);
        drive_sample(90000,   1'b0, 1, 65536, 0);
        wait_drain();

        // Randomized stream with phase/threshold changes, missing and early symbol marks.
        apply_reset(2);
        phase = 0;
        r = 65536;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) phase = $urandom_range(0, SPS - 1);
            if ($urandom_range(0, 19) == 0) r = $urandom_range(1, 131071);
            sym = (m_cnt == 0);
            if ($urandom_range(0, 19) == 0) sym = ~sym;
            case ($urandom_range(0, 7))
                0: y = r;
                1: y = r - 1;
                2: y = 0;
                3: y = -1;
                4: y = -r;
                5: y = -r - 1;
                default: y = int'($urandom_range(0, 262143)) - 131072;
            endcase
            drive_sample(y, sym, phase, r, $urandom_range(0, 2));
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound for the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
